// File: rtl/regfile_board_probe_pkg.sv
// Shared definitions for the register-file board probe: FSM encoding,
// the write-pattern table and the slice-select width derivation.
package regfile_probe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SCAN = 2'd2
    } probe_state_e;

    localparam logic [31:0] PAT0 = 32'h0000_0003;
    localparam logic [31:0] PAT1 = 32'h0000_0607;
    localparam logic [31:0] PAT2 = 32'hFFFF_FFFF;
    localparam logic [31:0] PAT3 = 32'h1111_1234;

    // 32-bit pattern word; the owner widens entry 2 to all ones of its own width
    function automatic logic [31:0] pat_word_f(input logic [1:0] idx);
        logic [31:0] v;
        case (idx)
            2'd0:    v = PAT0;
            2'd1:    v = PAT1;
            2'd2:    v = PAT2;
            2'd3:    v = PAT3;
            default: v = PAT0;
        endcase
        return v;
    endfunction

    function automatic int sel_w_f(input int data_w, input int led_w);
        int w;
        w = $clog2(data_w / led_w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/regfile_board_probe_if.sv
// Switch/button/LED bundle between the board and the register-file probe.
interface regfile_board_probe_if #(
    parameter int ADDR_W = 5,
    parameter int LED_W  = 8,
    parameter int SEL_W  = 2
);
    logic [ADDR_W-1:0] Addr;
    logic              Write_Reg;
    logic              Wr_Btn;
    logic [SEL_W-1:0]  C1;
    logic              C2;
    logic              Scan_En;
    logic [LED_W-1:0]  LED;
    logic [ADDR_W-1:0] Scan_Addr;
    logic              Busy;

    modport master (
        output Addr, Write_Reg, Wr_Btn, C1, C2, Scan_En,
        input  LED, Scan_Addr, Busy
    );

    modport slave (
        input  Addr, Write_Reg, Wr_Btn, C1, C2, Scan_En,
        output LED, Scan_Addr, Busy
    );
endinterface

// File: rtl/regfile_board_probe_reg_file.sv
// Parametrised register file: two combinational read ports, one synchronous
// write port, synchronous clear, register 0 hardwired to zero.
module reg_file_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [DEPTH];

    // Storage update: clear on reset, otherwise write anything but register 0
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_r[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_r[rd_addr_b];

endmodule

// File: rtl/regfile_board_probe.sv
// Board exerciser around one reg_file_param: manual writes, bulk fill,
// manual readback and timed auto-scan of every register onto the LEDs.
module regfile_board_probe
    import regfile_probe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LED_W    = 8,
    parameter int HOLD_CYC = 25000000
) (
    input logic                  Clk,
    input logic                  Reset,
    regfile_board_probe_if.slave bus
);
    localparam int SEL_W   = sel_w_f(DATA_W, LED_W);
    localparam int N_SLICE = DATA_W / LED_W;
    localparam int CNT_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(HOLD_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    probe_state_e      state_r;
    logic [ADDR_W-1:0] scan_addr_r;
    logic [CNT_W-1:0]  hold_cnt_r;
    logic              btn_q_r;
    logic [LED_W-1:0]  led_r;
    logic              busy_r;

    logic              btn_edge_s;
    logic [SEL_W-1:0]  c1_s;
    logic [1:0]        pat_idx_s;
    logic [DATA_W-1:0] pat_s;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [ADDR_W-1:0] rd_addr_a_s;
    logic [DATA_W-1:0] rd_a_s;
    logic [DATA_W-1:0] rd_b_s;

    function automatic logic [DATA_W-1:0] pat_f(input logic [1:0] idx);
        logic [DATA_W-1:0] v;
        case (idx)
            2'd2:    v = {DATA_W{1'b1}};
            default: v = DATA_W'(pat_word_f(idx));
        endcase
        return v;
    endfunction

    // Out-of-range selects fall back to slice 0
    function automatic logic [LED_W-1:0] slice_f(input logic [DATA_W-1:0] d,
                                                 input logic [SEL_W-1:0]  k);
        logic [LED_W-1:0] v;
        v = d[LED_W-1:0];
        for (int i = 0; i < N_SLICE; i++) begin
            if (k == SEL_W'(i)) begin
                v = d[i*LED_W +: LED_W];
            end
        end
        return v;
    endfunction

    assign c1_s       = bus.C1;
    assign pat_idx_s  = 2'(c1_s);
    assign pat_s      = pat_f(pat_idx_s);
    assign btn_edge_s = bus.Wr_Btn & ~btn_q_r;

    // Write-port steering: single press write in IDLE, sequential pattern in FILL
    always_comb begin
        we_s    = 1'b0;
        waddr_s = '0;
        wdata_s = '0;
        case (state_r)
            IDLE: begin
                if (bus.Write_Reg && !bus.C2 && btn_edge_s) begin
                    we_s    = 1'b1;
                    waddr_s = bus.Addr;
                    wdata_s = pat_s;
                end else begin
                    we_s    = 1'b0;
                end
            end
            FILL: begin
                we_s    = 1'b1;
                waddr_s = scan_addr_r;
                wdata_s = pat_f(scan_addr_r[1:0]);
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Port A follows the scan pointer while scanning, the switches otherwise
    always_comb begin
        if (state_r == SCAN) begin
            rd_addr_a_s = scan_addr_r;
        end else begin
            rd_addr_a_s = bus.Addr;
        end
    end

    reg_file_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_file (
        .clk       (Clk),
        .reset     (Reset),
        .wr_en     (we_s),
        .wr_addr   (waddr_s),
        .wr_data   (wdata_s),
        .rd_addr_a (rd_addr_a_s),
        .rd_addr_b (bus.Addr),
        .rd_data_a (rd_a_s),
        .rd_data_b (rd_b_s)
    );

    // Probe FSM with its counters, button edge register and LED register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r     <= IDLE;
            scan_addr_r <= '0;
            hold_cnt_r  <= '0;
            btn_q_r     <= 1'b0;
            led_r       <= '0;
            busy_r      <= 1'b0;
        end else begin
            btn_q_r <= bus.Wr_Btn;
            case (state_r)
                IDLE: begin
                    if (bus.Write_Reg) begin
                        if (btn_edge_s && bus.C2) begin
                            state_r     <= FILL;
                            scan_addr_r <= '0;
                            busy_r      <= 1'b1;
                        end else if (!btn_edge_s) begin
                            led_r <= pat_s[LED_W-1:0];
                        end
                    end else if (bus.Scan_En) begin
                        state_r     <= SCAN;
                        scan_addr_r <= '0;
                        hold_cnt_r  <= '0;
                        busy_r      <= 1'b1;
                    end else begin
                        led_r <= slice_f(bus.C2 ? rd_b_s : rd_a_s, c1_s);
                    end
                end
                FILL: begin
                    if (scan_addr_r == ADDR_MAX) begin
                        state_r     <= IDLE;
                        scan_addr_r <= '0;
                        busy_r      <= 1'b0;
                    end else begin
                        scan_addr_r <= scan_addr_r + 1'b1;
                    end
                end
                SCAN: begin
                    if (!bus.Scan_En || bus.Write_Reg) begin
                        state_r     <= IDLE;
                        scan_addr_r <= '0;
                        hold_cnt_r  <= '0;
                        busy_r      <= 1'b0;
                    end else begin
                        led_r <= slice_f(rd_a_s, c1_s);
                        if (hold_cnt_r == HOLD_MAX) begin
                            hold_cnt_r  <= '0;
                            scan_addr_r <= scan_addr_r + 1'b1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    scan_addr_r <= '0;
                    hold_cnt_r  <= '0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LED       = led_r;
    assign bus.Scan_Addr = scan_addr_r;
    assign bus.Busy      = busy_r;

endmodule

// File: tb/tb_regfile_board_probe.sv
// Directed bench for regfile_board_probe with HOLD_CYC=4 and hand-computed expectations.
module tb_regfile_board_probe;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    regfile_board_probe_if #(.ADDR_W(5), .LED_W(8), .SEL_W(2)) bus ();

    regfile_board_probe #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .LED_W    (8),
        .HOLD_CYC (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        bus.Wr_Btn = 1'b1;
        tick();
        bus.Wr_Btn = 1'b0;
        tick();
    endtask

    // Assemble a whole register from the four LED slices in read mode
    task automatic read_reg(input logic [4:0] addr, input logic port_b, output logic [31:0] val);
        bus.Write_Reg = 1'b0;
        bus.Scan_En   = 1'b0;
        bus.Wr_Btn    = 1'b0;
        bus.Addr      = addr;
        bus.C2        = port_b;
        for (int s = 0; s < 4; s++) begin
            bus.C1 = 2'(s);
            tick();
            val[s*8 +: 8] = bus.LED;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          cnt;
        int          mism;

        n_total = 0;
        n_pass  = 0;
        rst           = 1'b1;
        bus.Addr      = 5'd0;
        bus.Write_Reg = 1'b0;
        bus.Wr_Btn    = 1'b0;
        bus.C1        = 2'd0;
        bus.C2        = 1'b0;
        bus.Scan_En   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // 1: reset state
        bus.Addr = 5'd3;
        tick();
        check_val("reset_led", 32'(bus.LED), 32'h00);
        check_val("reset_busy", 32'(bus.Busy), 32'h0);
        check_val("reset_scan_addr", 32'(bus.Scan_Addr), 32'h0);

        // 2: single write of PAT[3] to reg5, preview first
        bus.Write_Reg = 1'b1;
        bus.C2        = 1'b0;
        bus.Addr      = 5'd5;
        bus.C1        = 2'd3;
        tick();
        check_val("preview_pat3", 32'(bus.LED), 32'h34);
        press();
        read_reg(5'd5, 1'b0, v);
        check_val("reg5_pat3_a", v, 32'h1111_1234);
        read_reg(5'd5, 1'b1, v);
        check_val("reg5_pat3_b", v, 32'h1111_1234);

        // 3: held button writes once; pattern change while held must not land
        bus.Write_Reg = 1'b1;
        bus.C2        = 1'b0;
        bus.Addr      = 5'd5;
        bus.C1        = 2'd1;
        bus.Wr_Btn    = 1'b1;
        tick();
        bus.C1 = 2'd2;
        repeat (9) tick();
        check_val("preview_pat2", 32'(bus.LED), 32'hFF);
        bus.Wr_Btn = 1'b0;
        tick();
        read_reg(5'd5, 1'b0, v);
        check_val("reg5_one_write", v, 32'h0000_0607);
        bus.Write_Reg = 1'b1;
        bus.Addr      = 5'd0;
        bus.C1        = 2'd2;
        tick();
        press();
        read_reg(5'd0, 1'b0, v);
        check_val("reg0_a", v, 32'h0);
        read_reg(5'd0, 1'b1, v);
        check_val("reg0_b", v, 32'h0);

        // 4: FILL lasts 32 cycles and ignores switches and presses
        bus.Write_Reg = 1'b1;
        bus.C2        = 1'b1;
        bus.Wr_Btn    = 1'b0;
        tick();
        bus.Wr_Btn = 1'b1;
        tick();
        bus.Addr = 5'd10;
        bus.C1   = 2'd0;
        bus.C2   = 1'b0;
        cnt      = 0;
        while (bus.Busy && cnt < 100) begin
            cnt++;
            bus.Wr_Btn = cnt[0];
            tick();
        end
        bus.Write_Reg = 1'b0;
        bus.Wr_Btn    = 1'b0;
        check_val("fill_busy_cycles", 32'(cnt), 32'd32);
        read_reg(5'd6, 1'b0, v);
        check_val("fill_reg6", v, 32'hFFFF_FFFF);
        read_reg(5'd7, 1'b1, v);
        check_val("fill_reg7", v, 32'h1111_1234);
        read_reg(5'd0, 1'b0, v);
        check_val("fill_reg0", v, 32'h0);
        read_reg(5'd1, 1'b0, v);
        check_val("fill_reg1", v, 32'h0000_0607);
        read_reg(5'd4, 1'b1, v);
        check_val("fill_reg4", v, 32'h0000_0003);
        read_reg(5'd10, 1'b0, v);
        check_val("fill_reg10", v, 32'hFFFF_FFFF);
        read_reg(5'd31, 1'b0, v);
        check_val("fill_reg31", v, 32'h1111_1234);

        // 5: SCAN steps every 4 cycles and wraps 31 -> 0
        bus.Write_Reg = 1'b0;
        bus.C2        = 1'b0;
        bus.C1        = 2'd0;
        bus.Scan_En   = 1'b1;
        mism          = 0;
        for (int i = 0; i < 132; i++) begin
            tick();
            if (32'(bus.Scan_Addr) != ((i / 4) % 32)) mism++;
            if (i == 0) check_val("scan_busy", 32'(bus.Busy), 32'h1);
            if (i == 2) check_val("scan_led_addr0", 32'(bus.LED), 32'h00);
            if (i == 6) check_val("scan_led_addr1", 32'(bus.LED), 32'h07);
        end
        check_val("scan_addr_seq_errors", 32'(mism), 32'd0);

        // 6: reset in the middle of SCAN at address 9
        cnt = 0;
        while (bus.Scan_Addr != 5'd9 && cnt < 200) begin
            cnt++;
            tick();
        end
        check_val("scan_reach9", 32'(bus.Scan_Addr), 32'd9);
        tick();
        rst = 1'b1;
        tick();
        check_val("midscan_reset_led", 32'(bus.LED), 32'h00);
        check_val("midscan_reset_scan_addr", 32'(bus.Scan_Addr), 32'h0);
        check_val("midscan_reset_busy", 32'(bus.Busy), 32'h0);
        rst         = 1'b0;
        bus.Scan_En = 1'b0;
        read_reg(5'd5, 1'b0, v);
        check_val("cleared_reg5", v, 32'h0);
        read_reg(5'd6, 1'b1, v);
        check_val("cleared_reg6", v, 32'h0);
        read_reg(5'd31, 1'b0, v);
        check_val("cleared_reg31", v, 32'h0);

        // SCAN left by Write_Reg=1
        bus.Scan_En = 1'b1;
        tick();
        tick();
        check_val("rescan_busy", 32'(bus.Busy), 32'h1);
        bus.Write_Reg = 1'b1;
        tick();
        check_val("scan_exit_busy", 32'(bus.Busy), 32'h0);
        check_val("scan_exit_addr", 32'(bus.Scan_Addr), 32'h0);

        // Button edge together with Scan_En: Write_Reg=1 picks the write
        bus.Addr = 5'd2;
        bus.C1   = 2'd3;
        bus.C2   = 1'b0;
        tick();
        press();
        check_val("simul_busy", 32'(bus.Busy), 32'h0);
        read_reg(5'd2, 1'b0, v);
        check_val("simul_reg2", v, 32'h1111_1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
